// File: rtl/alu_pkg.sv
// Shared constants, state encoding and small decode helpers for the ALU issue/retire controller.
package alu_pkg;

   localparam logic [3:0] ALU_AND  = 4'b0000;
   localparam logic [3:0] ALU_OR   = 4'b0001;
   localparam logic [3:0] ALU_ADD  = 4'b0010;
   localparam logic [3:0] ALU_SLL  = 4'b0011;
   localparam logic [3:0] ALU_SLT  = 4'b0100;
   localparam logic [3:0] ALU_SLTU = 4'b0101;
   localparam logic [3:0] ALU_SUB  = 4'b0110;
   localparam logic [3:0] ALU_XOR  = 4'b0111;
   localparam logic [3:0] ALU_SRL  = 4'b1000;
   localparam logic [3:0] ALU_SRA  = 4'b1010;

   localparam logic [6:0] OP_R  = 7'b0110011;
   localparam logic [6:0] OP_I  = 7'b0010011;
   localparam logic [6:0] OP_BR = 7'b1100011;

   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      DONE = 2'd2
   } state_e;

   typedef struct packed {
      logic wb_en;
      logic branch;
      logic illegal;
   } meta_t;

   // alt selects SUB for funct3 000 and SRA for funct3 101
   function automatic logic [3:0] alu_op_f3(input logic [2:0] f3, input logic alt);
      logic [3:0] op;
      case (f3)
         3'b000:  op = alt ? ALU_SUB : ALU_ADD;
         3'b001:  op = ALU_SLL;
         3'b010:  op = ALU_SLT;
         3'b011:  op = ALU_SLTU;
         3'b100:  op = ALU_XOR;
         3'b101:  op = alt ? ALU_SRA : ALU_SRL;
         3'b110:  op = ALU_OR;
         default: op = ALU_AND;
      endcase
      return op;
   endfunction

   function automatic logic branch_taken(input logic [2:0] f3, input logic zf, input logic lt);
      logic t;
      case (f3)
         F3_BEQ:           t = zf;
         F3_BNE:           t = !zf;
         F3_BLT, F3_BLTU:  t = lt;
         default:          t = !lt;
      endcase
      return t;
   endfunction

endpackage

// File: rtl/alu_decode.sv
// Combinational RV32I decode: opcode/funct3/imm field to ALU op code, operands and retire flags.
module alu_decode
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [6:0]   opcode,
   input  logic [2:0]   funct3,
   input  logic [11:0]  imm12,
   input  logic [N-1:0] rs1_val,
   input  logic [N-1:0] rs2_val,
   output logic [3:0]   ctrl,
   output logic [N-1:0] op_a,
   output logic [N-1:0] op_b,
   output logic         wb_en,
   output logic         branch,
   output logic         illegal
);

   always_comb begin
      ctrl    = ALU_AND;
      op_a    = rs1_val;
      op_b    = rs2_val;
      wb_en   = 1'b0;
      branch  = 1'b0;
      illegal = 1'b0;
      case (opcode)
         OP_R: begin
            ctrl  = alu_op_f3(funct3, imm12[10]);
            wb_en = 1'b1;
         end
         OP_I: begin
            // imm12[10] is inst[30]; only shifts use it, ADDI never subtracts
            ctrl  = alu_op_f3(funct3, imm12[10] && (funct3 == 3'b101));
            wb_en = 1'b1;
            if (funct3 == 3'b001 || funct3 == 3'b101)
               op_b = {{(N-5){1'b0}}, imm12[4:0]};
            else
               op_b = {{(N-12){imm12[11]}}, imm12};
         end
         OP_BR: begin
            case (funct3)
               F3_BEQ, F3_BNE: begin
                  ctrl   = ALU_SUB;
                  branch = 1'b1;
               end
               F3_BLT, F3_BGE: begin
                  ctrl   = ALU_SLT;
                  branch = 1'b1;
               end
               F3_BLTU, F3_BGEU: begin
                  ctrl   = ALU_SLTU;
                  branch = 1'b1;
               end
               default: illegal = 1'b1;
            endcase
         end
         default: illegal = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_issue_ctrl.sv
// Execute-stage issue/retire controller: registers ALU inputs on acceptance, captures the
// ALU result one cycle later and presents a write-back/branch record until downstream takes it.
module alu_issue_ctrl
   import alu_pkg::*;
#(
   parameter int N = 32
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [31:0]  in_inst,
   input  logic [N-1:0] in_rs1_val,
   input  logic [N-1:0] in_rs2_val,
   output logic [N-1:0] alu_rs1,
   output logic [N-1:0] alu_rs2,
   output logic [3:0]   alu_ctrl,
   output logic [31:0]  alu_inst,
   input  logic [N-1:0] alu_res,
   input  logic         alu_zf,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [N-1:0] out_result,
   output logic [4:0]   out_rd,
   output logic         out_wb_en,
   output logic         out_branch,
   output logic         out_taken,
   output logic         out_illegal,
   output logic [1:0]   dbg_state
);

   // Handshakes: a transfer happens on a rising edge where valid && ready; valid never
   // depends on ready, and a presented record holds all fields until it is taken.

   state_e       state_q, state_d;
   logic [N-1:0] alu_rs1_q, alu_rs1_d;
   logic [N-1:0] alu_rs2_q, alu_rs2_d;
   logic [3:0]   alu_ctrl_q, alu_ctrl_d;
   logic [31:0]  alu_inst_q, alu_inst_d;
   meta_t        meta_q, meta_d;
   logic [N-1:0] out_result_q, out_result_d;
   logic [4:0]   out_rd_q, out_rd_d;
   logic         out_wb_en_q, out_wb_en_d;
   logic         out_branch_q, out_branch_d;
   logic         out_taken_q, out_taken_d;
   logic         out_illegal_q, out_illegal_d;

   logic [3:0]   dec_ctrl;
   logic [N-1:0] dec_a, dec_b;
   logic         dec_wb_en, dec_branch, dec_illegal;
   logic         accept;

   alu_decode #(.N(N)) u_decode (
      .opcode  (in_inst[6:0]),
      .funct3  (in_inst[14:12]),
      .imm12   (in_inst[31:20]),
      .rs1_val (in_rs1_val),
      .rs2_val (in_rs2_val),
      .ctrl    (dec_ctrl),
      .op_a    (dec_a),
      .op_b    (dec_b),
      .wb_en   (dec_wb_en),
      .branch  (dec_branch),
      .illegal (dec_illegal)
   );

   assign in_ready = (state_q == IDLE) || (state_q == DONE && out_ready);
   assign accept   = in_valid && in_ready;

   always_comb begin
      state_d       = state_q;
      alu_rs1_d     = alu_rs1_q;
      alu_rs2_d     = alu_rs2_q;
      alu_ctrl_d    = alu_ctrl_q;
      alu_inst_d    = alu_inst_q;
      meta_d        = meta_q;
      out_result_d  = out_result_q;
      out_rd_d      = out_rd_q;
      out_wb_en_d   = out_wb_en_q;
      out_branch_d  = out_branch_q;
      out_taken_d   = out_taken_q;
      out_illegal_d = out_illegal_q;

      case (state_q)
         IDLE: if (in_valid) state_d = EXEC;
         EXEC: begin
            state_d       = DONE;
            out_result_d  = alu_res;
            out_rd_d      = alu_inst_q[11:7];
            out_wb_en_d   = meta_q.wb_en;
            out_branch_d  = meta_q.branch;
            out_illegal_d = meta_q.illegal;
            out_taken_d   = meta_q.branch && branch_taken(alu_inst_q[14:12], alu_zf, alu_res[0]);
         end
         DONE: if (out_ready) state_d = in_valid ? EXEC : IDLE;
         default: state_d = IDLE;
      endcase

      if (accept) begin
         alu_rs1_d  = dec_a;
         alu_rs2_d  = dec_b;
         alu_ctrl_d = dec_ctrl;
         alu_inst_d = in_inst;
         meta_d     = '{wb_en: dec_wb_en, branch: dec_branch, illegal: dec_illegal};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         alu_rs1_q     <= '0;
         alu_rs2_q     <= '0;
         alu_ctrl_q    <= '0;
         alu_inst_q    <= '0;
         meta_q        <= '0;
         out_result_q  <= '0;
         out_rd_q      <= '0;
         out_wb_en_q   <= 1'b0;
         out_branch_q  <= 1'b0;
         out_taken_q   <= 1'b0;
         out_illegal_q <= 1'b0;
      end else begin
         state_q       <= state_d;
         alu_rs1_q     <= alu_rs1_d;
         alu_rs2_q     <= alu_rs2_d;
         alu_ctrl_q    <= alu_ctrl_d;
         alu_inst_q    <= alu_inst_d;
         meta_q        <= meta_d;
         out_result_q  <= out_result_d;
         out_rd_q      <= out_rd_d;
         out_wb_en_q   <= out_wb_en_d;
         out_branch_q  <= out_branch_d;
         out_taken_q   <= out_taken_d;
         out_illegal_q <= out_illegal_d;
      end
   end

   assign alu_rs1     = alu_rs1_q;
   assign alu_rs2     = alu_rs2_q;
   assign alu_ctrl    = alu_ctrl_q;
   assign alu_inst    = alu_inst_q;
   assign out_valid   = (state_q == DONE);
   assign out_result  = out_result_q;
   assign out_rd      = out_rd_q;
   assign out_wb_en   = out_wb_en_q;
   assign out_branch  = out_branch_q;
   assign out_taken   = out_taken_q;
   assign out_illegal = out_illegal_q;
   assign dbg_state   = state_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: an ALU model closes the loop, an instruction-level model predicts
// every ALU-side and retire-side output, and directed vectors pin specific literal values.
module tb_alu_issue_ctrl;

   localparam int N = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         in_valid = 1'b0;
   logic         in_ready;
   logic [31:0]  in_inst = '0;
   logic [N-1:0] in_rs1_val = '0;
   logic [N-1:0] in_rs2_val = '0;
   logic [N-1:0] alu_rs1, alu_rs2;
   logic [3:0]   alu_ctrl;
   logic [31:0]  alu_inst;
   logic [N-1:0] alu_res;
   logic         alu_zf;
   logic         out_valid;
   logic         out_ready = 1'b1;
   logic [N-1:0] out_result;
   logic [4:0]   out_rd;
   logic         out_wb_en, out_branch, out_taken, out_illegal;
   logic [1:0]   dbg_state;

   int n_chk  = 0;
   int n_pass = 0;
   logic chk_en = 1'b0;

   always #5 clk = ~clk;

   alu_issue_ctrl #(.N(N)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .in_inst     (in_inst),
      .in_rs1_val  (in_rs1_val),
      .in_rs2_val  (in_rs2_val),
      .alu_rs1     (alu_rs1),
      .alu_rs2     (alu_rs2),
      .alu_ctrl    (alu_ctrl),
      .alu_inst    (alu_inst),
      .alu_res     (alu_res),
      .alu_zf      (alu_zf),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .out_result  (out_result),
      .out_rd      (out_rd),
      .out_wb_en   (out_wb_en),
      .out_branch  (out_branch),
      .out_taken   (out_taken),
      .out_illegal (out_illegal),
      .dbg_state   (dbg_state)
   );

   // ALU attached to the DUT
   function automatic logic [31:0] alu_fn(input logic [3:0] c, input logic [31:0] a, input logic [31:0] b);
      logic signed [31:0] sa, sb;
      sa = a;
      sb = b;
      case (c)
         4'b0010: return a + b;
         4'b0110: return a - b;
         4'b0000: return a & b;
         4'b0001: return a | b;
         4'b0011: return a << b[4:0];
         4'b0100: return {31'd0, sa < sb};
         4'b0101: return {31'd0, a < b};
         4'b0111: return a ^ b;
         4'b1000: return a >> b[4:0];
         4'b1010: return sa >>> b[4:0];
         default: return 32'd0;
      endcase
   endfunction

   always_comb begin
      alu_res = alu_fn(alu_ctrl, alu_rs1, alu_rs2);
      alu_zf  = (alu_res == '0);
   end

   typedef struct packed {
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] inst;
   } alu_t;

   typedef struct packed {
      logic [31:0] result;
      logic [4:0]  rd;
      logic        wb;
      logic        br;
      logic        taken;
      logic        ill;
   } rec_t;

   // Instruction semantics straight from the ISA: what the ALU must be told and what retires.
   function automatic void predict(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b,
                                   output alu_t al, output rec_t rc);
      logic [6:0] op;
      logic [2:0] f3;
      logic [31:0] y;
      logic signed [31:0] sa, sy;
      op = inst[6:0];
      f3 = inst[14:12];
      al.ctrl = 4'b0000;
      al.a    = a;
      al.b    = b;
      al.inst = inst;
      rc      = '0;
      rc.rd   = inst[11:7];
      if (op == 7'b0110011 || op == 7'b0010011) begin
         if (op == 7'b0110011)             y = b;
         else if (f3 == 3'd1 || f3 == 3'd5) y = {27'd0, inst[24:20]};
         else                               y = {{20{inst[31]}}, inst[31:20]};
         sa = a;
         sy = y;
         al.b  = y;
         rc.wb = 1'b1;
         case (f3)
            3'd0: if (op == 7'b0110011 && inst[30]) begin al.ctrl = 4'b0110; rc.result = a - y; end
                  else begin al.ctrl = 4'b0010; rc.result = a + y; end
            3'd1: begin al.ctrl = 4'b0011; rc.result = a << y[4:0]; end
            3'd2: begin al.ctrl = 4'b0100; rc.result = {31'd0, sa < sy}; end
            3'd3: begin al.ctrl = 4'b0101; rc.result = {31'd0, a < y}; end
            3'd4: begin al.ctrl = 4'b0111; rc.result = a ^ y; end
            3'd5: if (inst[30]) begin al.ctrl = 4'b1010; rc.result = sa >>> y[4:0]; end
                  else begin al.ctrl = 4'b1000; rc.result = a >> y[4:0]; end
            3'd6: begin al.ctrl = 4'b0001; rc.result = a | y; end
            default: begin al.ctrl = 4'b0000; rc.result = a & y; end
         endcase
      end else if (op == 7'b1100011 && f3 != 3'd2 && f3 != 3'd3) begin
         sa = a;
         sy = b;
         rc.br = 1'b1;
         case (f3)
            3'd0: begin al.ctrl = 4'b0110; rc.result = a - b; rc.taken = (a == b); end
            3'd1: begin al.ctrl = 4'b0110; rc.result = a - b; rc.taken = (a != b); end
            3'd4: begin al.ctrl = 4'b0100; rc.result = {31'd0, sa < sy}; rc.taken = (sa < sy); end
            3'd5: begin al.ctrl = 4'b0100; rc.result = {31'd0, sa < sy}; rc.taken = (sa >= sy); end
            3'd6: begin al.ctrl = 4'b0101; rc.result = {31'd0, a < b}; rc.taken = (a < b); end
            default: begin al.ctrl = 4'b0101; rc.result = {31'd0, a < b}; rc.taken = (a >= b); end
         endcase
      end else begin
         rc.ill    = 1'b1;
         rc.result = a & b;
      end
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, act, exp, $time);
   endtask

   // Model: one record in the ALU (m_busy) and/or one record offered downstream (m_has)
   logic m_busy = 1'b0;
   logic m_has  = 1'b0;
   alu_t m_alu  = '0;
   rec_t m_next = '0;
   rec_t m_rec  = '0;

   initial forever begin
      @(posedge clk);
      if (rst) begin
         m_busy = 1'b0;
         m_has  = 1'b0;
         m_alu  = '0;
      end else begin
         logic rdy;
         rdy = (!m_busy && !m_has) || (m_has && out_ready);
         if (m_has && out_ready) m_has = 1'b0;
         if (m_busy) begin
            m_has  = 1'b1;
            m_busy = 1'b0;
            m_rec  = m_next;
         end
         if (in_valid && rdy) begin
            predict(in_inst, in_rs1_val, in_rs2_val, m_alu, m_next);
            m_busy = 1'b1;
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_en) begin
         check("in_ready", {31'd0, in_ready}, {31'd0, (!m_busy && !m_has) || (m_has && out_ready)});
         check("out_valid", {31'd0, out_valid}, {31'd0, m_has});
         check("alu_ctrl", {28'd0, alu_ctrl}, {28'd0, m_alu.ctrl});
         check("alu_rs1", alu_rs1, m_alu.a);
         check("alu_rs2", alu_rs2, m_alu.b);
         check("alu_inst", alu_inst, m_alu.inst);
         if (m_has) begin
            check("out_result", out_result, m_rec.result);
            check("out_rd", {27'd0, out_rd}, {27'd0, m_rec.rd});
            check("out_wb_en", {31'd0, out_wb_en}, {31'd0, m_rec.wb});
            check("out_branch", {31'd0, out_branch}, {31'd0, m_rec.br});
            check("out_taken", {31'd0, out_taken}, {31'd0, m_rec.taken});
            check("out_illegal", {31'd0, out_illegal}, {31'd0, m_rec.ill});
         end
      end
   end

   function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3, input logic [4:0] rd);
      return {f7, 5'd2, 5'd1, f3, rd, 7'b0110011};
   endfunction

   function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [2:0] f3, input logic [4:0] rd);
      return {imm, 5'd1, f3, rd, 7'b0010011};
   endfunction

   function automatic logic [31:0] enc_b(input logic [2:0] f3);
      return {7'd0, 5'd2, 5'd1, f3, 5'd0, 7'b1100011};
   endfunction

   // Drives one instruction from a falling edge until accepted; returns 1 time unit after the accepting edge.
   task automatic issue(input logic [31:0] inst, input logic [31:0] a, input logic [31:0] b);
      logic acc;
      int n;
      acc = 1'b0;
      n = 0;
      while (!acc && n < 40) begin
         @(negedge clk);
         in_valid   = 1'b1;
         in_inst    = inst;
         in_rs1_val = a;
         in_rs2_val = b;
         acc = in_ready;
         @(posedge clk);
         n++;
      end
      #1 in_valid = 1'b0;
      if (!acc) check("issue_accept_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: run did not reach the end");
      n_chk++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      chk_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_alu_ctrl", {28'd0, alu_ctrl}, 32'd0);
      check("rst_alu_inst", alu_inst, 32'd0);
      check("rst_state", {30'd0, dbg_state}, 32'd0);

      // ADD x3, x1, x2 with 5 + 7
      issue(32'h002081B3, 32'd5, 32'd7);
      @(negedge clk);
      check("add_ctrl", {28'd0, alu_ctrl}, 32'h2);
      check("add_out_valid_exec", {31'd0, out_valid}, 32'd0);
      @(negedge clk);
      check("add_result", out_result, 32'd12);
      check("add_rd", {27'd0, out_rd}, 32'd3);
      check("add_wb_en", {31'd0, out_wb_en}, 32'd1);

      // ADDI x5, x1, -1
      issue(enc_i(12'hFFF, 3'd0, 5'd5), 32'd100, 32'd0);
      @(negedge clk);
      check("addi_rs2", alu_rs2, 32'hFFFF_FFFF);
      check("addi_ctrl", {28'd0, alu_ctrl}, 32'h2);
      @(negedge clk);
      check("addi_result", out_result, 32'd99);

      // SRAI x6, x1, 4
      issue(enc_i(12'h404, 3'd5, 5'd6), 32'h8000_0000, 32'd0);
      @(negedge clk);
      check("srai_rs2", alu_rs2, 32'd4);
      check("srai_ctrl", {28'd0, alu_ctrl}, 32'hA);
      @(negedge clk);
      check("srai_result", out_result, 32'hF800_0000);

      // BEQ 9, 9
      issue(enc_b(3'd0), 32'd9, 32'd9);
      repeat (2) @(negedge clk);
      check("beq_branch", {31'd0, out_branch}, 32'd1);
      check("beq_taken", {31'd0, out_taken}, 32'd1);
      check("beq_wb_en", {31'd0, out_wb_en}, 32'd0);

      // BGE -1, 0
      issue(enc_b(3'd5), 32'hFFFF_FFFF, 32'd0);
      repeat (2) @(negedge clk);
      check("bge_taken", {31'd0, out_taken}, 32'd0);
      check("bge_result", out_result, 32'd1);

      // Load opcode is unsupported
      issue({12'h010, 5'd1, 3'b010, 5'd6, 7'b0000011}, 32'd3, 32'd4);
      @(negedge clk);
      check("load_ctrl", {28'd0, alu_ctrl}, 32'd0);
      @(negedge clk);
      check("load_illegal", {31'd0, out_illegal}, 32'd1);
      check("load_wb_en", {31'd0, out_wb_en}, 32'd0);

      // Backpressure: SUB 10 - 3 stalls three cycles, then retires as the next one is accepted
      @(posedge clk);
      #1 out_ready = 1'b0;
      issue(enc_r(7'h20, 3'd0, 5'd4), 32'd10, 32'd3);
      fork
         issue(enc_r(7'h00, 3'd4, 5'd7), 32'hF0F0_0000, 32'h0FF0_00FF);
         begin
            repeat (4) @(posedge clk);
            #3 out_ready = 1'b1;
         end
         begin
            @(negedge clk);
            repeat (3) begin
               @(negedge clk);
               check("stall_out_valid", {31'd0, out_valid}, 32'd1);
               check("stall_in_ready", {31'd0, in_ready}, 32'd0);
               check("stall_result", out_result, 32'd7);
               check("stall_rd", {27'd0, out_rd}, 32'd4);
            end
         end
      join
      @(negedge clk);
      check("b2b_out_valid", {31'd0, out_valid}, 32'd0);
      check("b2b_alu_ctrl", {28'd0, alu_ctrl}, 32'h7);

      // Directed sweep, back-to-back where possible
      issue(enc_r(7'h00, 3'd1, 5'd8),  32'd1,          32'd33);
      issue(enc_r(7'h00, 3'd2, 5'd9),  32'hFFFF_FFFB, 32'd2);
      issue(enc_r(7'h00, 3'd3, 5'd10), 32'hFFFF_FFFB, 32'd2);
      issue(enc_r(7'h00, 3'd5, 5'd11), 32'h8000_0000, 32'd4);
      issue(enc_r(7'h20, 3'd5, 5'd12), 32'h8000_0000, 32'd4);
      issue(enc_r(7'h00, 3'd6, 5'd13), 32'h1200_0034, 32'h0056_7800);
      issue(enc_r(7'h00, 3'd7, 5'd14), 32'hFF00_FF00, 32'h0FF0_0FF0);
      issue(enc_r(7'h00, 3'd0, 5'd0),  32'd1,          32'd2);
      issue(enc_i(12'h400, 3'd0, 5'd15), 32'd1,        32'd99);
      issue(enc_i(12'hFFF, 3'd2, 5'd16), 32'hFFFF_FFFE, 32'd0);
      issue(enc_i(12'h01F, 3'd5, 5'd17), 32'h8000_0000, 32'd0);
      issue(enc_i(12'h003, 3'd1, 5'd18), 32'd5,        32'd0);
      issue(enc_i(12'h0FF, 3'd4, 5'd19), 32'h0000_0F0F, 32'd0);
      issue(enc_b(3'd1), 32'd4,          32'd4);
      issue(enc_b(3'd4), 32'hFFFF_FFFF, 32'd1);
      issue(enc_b(3'd6), 32'hFFFF_FFFF, 32'd1);
      issue(enc_b(3'd7), 32'hFFFF_FFFF, 32'd1);
      issue(enc_b(3'd5), 32'd3,          32'd3);
      issue(enc_b(3'd2), 32'd3,          32'd5);
      issue({20'h12345, 5'd3, 7'b0110111}, 32'd6, 32'd7);
      repeat (3) @(negedge clk);

      // Reset while the ALU is executing
      issue(enc_r(7'h20, 3'd0, 5'd21), 32'd50, 32'd8);
      rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("rst_exec_state", {30'd0, dbg_state}, 32'd0);
      check("rst_exec_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_exec_in_ready", {31'd0, in_ready}, 32'd1);
      check("rst_exec_alu_rs1", alu_rs1, 32'd0);
      check("rst_exec_alu_rs2", alu_rs2, 32'd0);
      check("rst_exec_alu_inst", alu_inst, 32'd0);
      check("rst_exec_result", out_result, 32'd0);
      check("rst_exec_rd", {27'd0, out_rd}, 32'd0);
      check("rst_exec_flags", {28'd0, out_wb_en, out_branch, out_taken, out_illegal}, 32'd0);
      repeat (2) @(negedge clk);
      check("rst_exec_no_record", {31'd0, out_valid}, 32'd0);

      // Recovery after reset
      issue(enc_r(7'h00, 3'd0, 5'd22), 32'd20, 32'd22);
      repeat (2) @(negedge clk);
      check("post_rst_result", out_result, 32'd42);
      repeat (3) @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
